// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory program loader and core hold control
//
// Loads load_len 32-bit words from a valid/ready host stream into instruction
// memory, then releases the core (RUN) and steers its fetch address onto the
// memory read port. Optional build macro IMEM_CHECKSUM_EN adds a CHECK step that
// compares the mod-2^32 sum of loaded words against exp_sum before RUN.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   start, abort          - begin a load / cancel a load in progress
//   load_len, exp_sum     - word count and expected checksum, sampled at start
//   host_data/valid/ready - program word stream
//   core_pc               - core fetch byte address
//   imem_raddr            - memory read word index (core_pc[31:2] in RUN)
//   imem_waddr/wdata/we   - registered memory write port
//   core_hold             - 1 holds the core in reset/stall
//   busy, done, error     - status; done pulses on every entry to RUN
//   word_count            - words written in the current load

module imem_load_ctrl #(
  parameter int DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [8:0]  load_len,
  input  logic [31:0] host_data,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [31:0] exp_sum,
  input  logic [31:0] core_pc,
  output logic [31:0] imem_raddr,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        imem_we,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t      state;
  logic [8:0]  len_q;
  logic [8:0]  wc_next;
  logic        accept;
  logic        unused_bits;

`ifdef IMEM_CHECKSUM_EN
  logic [31:0] checksum;
  logic [31:0] exp_q;
  assign unused_bits = ^core_pc[1:0];
`else
  assign unused_bits = ^{exp_sum, core_pc[1:0]};
`endif

  assign wc_next = word_count + 9'd1;
  // abort wins over a simultaneous handshake; that word is dropped
  assign accept  = (state == S_LOAD) && host_valid && !abort;

  assign host_ready = (state == S_LOAD);
  assign busy       = (state == S_LOAD) || (state == S_CHECK);
  assign error      = (state == S_ERROR);
  assign core_hold  = (state != S_RUN);
  assign imem_raddr = (state == S_RUN) ? {2'b00, core_pc[31:2]} : 32'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= 9'd0;
      word_count <= 9'd0;
      imem_we    <= 1'b0;
      imem_waddr <= 32'd0;
      imem_wdata <= 32'd0;
      done       <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      checksum   <= 32'd0;
      exp_q      <= 32'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE, S_RUN: begin
          if (start) begin
            if (load_len == 9'd0) begin
              state      <= S_RUN;
              done       <= 1'b1;
              word_count <= 9'd0;
            end else if (load_len > DEPTH_W) begin
              state <= S_ERROR;
            end else begin
              state      <= S_LOAD;
              len_q      <= load_len;
              word_count <= 9'd0;
`ifdef IMEM_CHECKSUM_EN
              checksum   <= 32'd0;
              exp_q      <= exp_sum;
`endif
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (accept) begin
            imem_we    <= 1'b1;
            imem_waddr <= {23'd0, word_count};
            imem_wdata <= host_data;
            word_count <= wc_next;
`ifdef IMEM_CHECKSUM_EN
            checksum   <= checksum + host_data;
            if (wc_next == len_q) state <= S_CHECK;
`else
            if (wc_next == len_q) begin
              state <= S_RUN;
              done  <= 1'b1;
            end
`endif
          end
        end
        S_CHECK: begin
`ifdef IMEM_CHECKSUM_EN
          if (abort) begin
            state <= S_IDLE;
          end else if (checksum == exp_q) begin
            state <= S_RUN;
            done  <= 1'b1;
          end else begin
            state <= S_ERROR;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl

module tb_imem_load_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [8:0]  load_len;
  logic [31:0] host_data;
  logic        host_valid;
  logic        host_ready;
  logic [31:0] exp_sum;
  logic [31:0] core_pc;
  logic [31:0] imem_raddr;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        imem_we;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  word_count;

  int n_tests = 0;
  int n_fail  = 0;

  imem_load_ctrl #(.DEPTH(256)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .load_len   (load_len),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .exp_sum    (exp_sum),
    .core_pc    (core_pc),
    .imem_raddr (imem_raddr),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .imem_we    (imem_we),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hold"},  32'(core_hold),  32'd1);
    chk({tag, "_wc"},    32'(word_count), 32'd0);
    chk({tag, "_we"},    32'(imem_we),    32'd0);
    chk({tag, "_waddr"}, imem_waddr,      32'd0);
    chk({tag, "_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_ready"}, 32'(host_ready), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_error"}, 32'(error),      32'd0);
    chk({tag, "_raddr"}, imem_raddr,      32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; load_len = 9'd0;
    host_data = 32'd0; host_valid = 1'b0; exp_sum = 32'd0; core_pc = 32'd0;
    tick();
    tick();
    chk_reset_vals("rst");
    reset = 1'b0;

    // main load: 3 words back-to-back
    start = 1'b1; load_len = 9'd3; exp_sum = 32'h00A2_00C5;
    tick();
    start = 1'b0;
    chk("ld_ready", 32'(host_ready), 32'd1);
    chk("ld_busy",  32'(busy),       32'd1);
    chk("ld_we0",   32'(imem_we),    32'd0);
    host_valid = 1'b1; host_data = 32'h00A2_00B3;
    tick();
    chk("w0_we", 32'(imem_we), 32'd1);
    chk("w0_addr", imem_waddr, 32'd0);
    chk("w0_data", imem_wdata, 32'h00A2_00B3);
    chk("w0_wc", 32'(word_count), 32'd1);
    host_data = 32'h0000_0013;
    tick();
    chk("w1_we", 32'(imem_we), 32'd1);
    chk("w1_addr", imem_waddr, 32'd1);
    chk("w1_data", imem_wdata, 32'h0000_0013);
    host_data = 32'hFFFF_FFFF;
    tick();
    chk("w2_we", 32'(imem_we), 32'd1);
    chk("w2_addr", imem_waddr, 32'd2);
    chk("w2_data", imem_wdata, 32'hFFFF_FFFF);
    chk("w2_wc", 32'(word_count), 32'd3);
    host_valid = 1'b0;
`ifdef IMEM_CHECKSUM_EN
    chk("chk_busy", 32'(busy), 32'd1);
    chk("chk_done", 32'(done), 32'd0);
    tick();
`endif
    chk("run_done", 32'(done), 32'd1);
    chk("run_hold", 32'(core_hold), 32'd0);
    chk("run_ready", 32'(host_ready), 32'd0);
    tick();
    chk("run_done_off", 32'(done), 32'd0);
    chk("run_we_off", 32'(imem_we), 32'd0);
    chk("run_wc", 32'(word_count), 32'd3);

    core_pc = 32'h0000_0008;
    #1;
    chk("raddr_8", imem_raddr, 32'd2);
    core_pc = 32'h0000_000C;
    #1;
    chk("raddr_c", imem_raddr, 32'd3);

    // reload from RUN with gapped valid; start during LOAD is ignored
    start = 1'b1; load_len = 9'd2; exp_sum = 32'd3;
    tick();
    start = 1'b0;
    chk("gap_hold", 32'(core_hold), 32'd1);
    chk("gap_wc0", 32'(word_count), 32'd0);
    host_valid = 1'b1; host_data = 32'd1;
    tick();
    chk("gap_w0_we", 32'(imem_we), 32'd1);
    chk("gap_w0_addr", imem_waddr, 32'd0);
    host_valid = 1'b0;
    start = 1'b1; load_len = 9'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b0;
      chk("gap_idle_we", 32'(imem_we), 32'd0);
      chk("gap_idle_busy", 32'(busy), 32'd1);
      chk("gap_idle_wc", 32'(word_count), 32'd1);
    end
    host_valid = 1'b1; host_data = 32'd2;
    tick();
    host_valid = 1'b0;
    chk("gap_w1_we", 32'(imem_we), 32'd1);
    chk("gap_w1_addr", imem_waddr, 32'd1);
`ifdef IMEM_CHECKSUM_EN
    chk("gap_chk_hold", 32'(core_hold), 32'd1);
    tick();
`endif
    chk("gap_done", 32'(done), 32'd1);
    chk("gap_run", 32'(core_hold), 32'd0);

    // abort together with the 2nd handshake of a 4-word load
    start = 1'b1; load_len = 9'd4;
    tick();
    start = 1'b0;
    host_valid = 1'b1; host_data = 32'h11;
    tick();
    chk("ab_w0_we", 32'(imem_we), 32'd1);
    host_data = 32'h22; abort = 1'b1;
    tick();
    abort = 1'b0; host_valid = 1'b0;
    chk("ab_we", 32'(imem_we), 32'd0);
    chk("ab_wc", 32'(word_count), 32'd1);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_hold", 32'(core_hold), 32'd1);
    chk("ab_ready", 32'(host_ready), 32'd0);

    // zero-length start goes straight to RUN
    start = 1'b1; load_len = 9'd0;
    tick();
    start = 1'b0;
    chk("z_done", 32'(done), 32'd1);
    chk("z_hold", 32'(core_hold), 32'd0);
    chk("z_wc", 32'(word_count), 32'd0);
    tick();
    chk("z_done_off", 32'(done), 32'd0);

    // oversize load -> sticky ERROR
    start = 1'b1; load_len = 9'd300;
    tick();
    chk("err_flag", 32'(error), 32'd1);
    chk("err_hold", 32'(core_hold), 32'd1);
    chk("err_raddr", imem_raddr, 32'd0);
    load_len = 9'd1;
    tick();
    start = 1'b0;
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_ready", 32'(host_ready), 32'd0);
    chk("err_busy", 32'(busy), 32'd0);

    // reset clears ERROR; then reset mid-load cancels the pending write
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 32'(error), 32'd0);
    start = 1'b1; load_len = 9'd3;
    tick();
    start = 1'b0;
    host_valid = 1'b1; host_data = 32'hDEAD_BEEF;
    tick();
    chk("mid_we", 32'(imem_we), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_vals("midrst");
    reset = 1'b0; host_valid = 1'b0;

`ifdef IMEM_CHECKSUM_EN
    // checksum mismatch -> ERROR
    start = 1'b1; load_len = 9'd2; exp_sum = 32'd4;
    tick();
    start = 1'b0;
    host_valid = 1'b1; host_data = 32'd1;
    tick();
    host_data = 32'd2;
    tick();
    host_valid = 1'b0;
    chk("cs_check_busy", 32'(busy), 32'd1);
    tick();
    chk("cs_err", 32'(error), 32'd1);
    chk("cs_hold", 32'(core_hold), 32'd1);
    chk("cs_done", 32'(done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter DEPTH, default 256: instruction memory size in 32-bit words; legal range 2..256.
REQ-002 Port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: one-cycle request to begin a program load.
REQ-005 Port abort, input, 1 bit: cancels a load in progress.
REQ-006 Port load_len, input, 9 bits: number of words to load, sampled when start is accepted.
REQ-007 Ports host_data (input, 32 bits), host_valid (input, 1 bit) and host_ready (output, 1 bit): program word stream using a valid/ready handshake.
REQ-008 Port exp_sum, input, 32 bits: expected load checksum, sampled at start.
REQ-009 Port core_pc, input, 32 bits: core fetch byte address.
REQ-010 Ports imem_raddr (output, 32 bits), imem_waddr (output, 32 bits), imem_wdata (output, 32 bits) and imem_we (output, 1 bit): drive the instruction memory Read1, WriteReg, WriteData and RegWrite pins; addresses are word indices.
REQ-011 Port core_hold, output, 1 bit: holds the core in reset/stall.
REQ-012 Ports busy, done and error, outputs, 1 bit each: status flags.
REQ-013 Port word_count, output, 9 bits: number of words written in the current load.

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, CHECK, RUN and ERROR.
REQ-015 In IDLE, start with 0 < load_len <= DEPTH -> LOAD; start with load_len == 0 -> RUN; start with load_len > DEPTH -> ERROR.
REQ-016 In LOAD, host_ready SHALL be 1 (combinational from state); every cycle with host_valid&host_ready is an accepted word.
REQ-017 An accepted word SHALL produce, on the next cycle only, imem_we=1, imem_waddr=word_count and imem_wdata=host_data, and word_count SHALL increment (1-cycle write latency).
REQ-018 Acceptance of word number load_len SHALL leave LOAD on the same edge; host_ready SHALL be 0 from the next cycle, so no extra word is accepted.
REQ-019 LOAD with no host_valid SHALL wait indefinitely with no timeout.
REQ-020 abort in LOAD or CHECK SHALL return to IDLE on the next edge; a write already registered SHALL still complete; abort SHALL take priority over a simultaneous handshake, and that word SHALL be dropped.
REQ-021 start in LOAD or CHECK SHALL be ignored.
REQ-022 In RUN, core_hold SHALL be 0 and imem_raddr SHALL equal core_pc[31:2] zero-extended (combinational).
REQ-023 Outside RUN, imem_raddr SHALL be 0 and core_hold SHALL be 1.
REQ-024 start in RUN SHALL re-enter LOAD (reload) with the same load_len checks; core_hold SHALL return to 1 on the next cycle.
REQ-025 done SHALL pulse for exactly 1 cycle on every entry to RUN.
REQ-026 busy SHALL equal (state==LOAD || state==CHECK).
REQ-027 ERROR SHALL be sticky until reset: error=1, core_hold=1, host_ready=0, and start is ignored.
REQ-028 word_count SHALL clear on each accepted start and hold its value in RUN and ERROR.

Reset
REQ-029 While reset is high on a clock edge, the block SHALL go to IDLE.
REQ-030 The reset values SHALL be: core_hold=1, word_count=0, checksum=0, imem_we=0, imem_waddr=0, imem_wdata=0, host_ready=0, busy=0, done=0, error=0, imem_raddr=0.
REQ-031 Reset SHALL take priority over start, abort and handshakes, including mid-load; a pending registered write SHALL be cancelled, giving imem_we=0 in the cycle after reset.

Configuration
REQ-032 With macro IMEM_CHECKSUM_EN defined, the block SHALL accumulate a checksum as the mod-2^32 sum of the accepted words.
REQ-033 With IMEM_CHECKSUM_EN defined, LOAD completion -> CHECK for 1 cycle, then checksum == exp_sum -> RUN, otherwise -> ERROR.
REQ-034 Without IMEM_CHECKSUM_EN, the block SHALL omit CHECK and the checksum register, go LOAD -> RUN directly, and ignore exp_sum; the port list SHALL be identical in both builds.

Verification
REQ-035 Reset, start, load_len=3, words 00A200B3/00000013/FFFFFFFF sent back-to-back -> three imem_we pulses at waddr 0,1,2 one cycle after each handshake, word_count=3, done pulse, core_hold=0.
REQ-036 In RUN with core_pc=0x00000008 -> imem_raddr=2; core_pc=0x0000000C -> imem_raddr=3.
REQ-037 load_len=2 with host_valid gapped (valid, idle 3 cycles, valid) -> exactly 2 writes, no write during gaps, RUN entered only after the second word.
REQ-038 abort asserted in the same cycle as the 2nd handshake of a load_len=4 load -> 1 write only, state IDLE, core_hold=1; with start, load_len=300 and DEPTH=256 -> error=1, which persists until reset.
REQ-039 With IMEM_CHECKSUM_EN: words 1 and 2 with exp_sum=3 -> RUN; with exp_sum=4 -> error=1, core_hold=1; reset asserted mid-load -> all outputs at their reset values on the next cycle.
